// File: rtl/dmem_lsu.sv
// Load/store unit between the execute stage and a single-port data memory.
// Holds one operation at a time: IDLE -> REQ -> WAIT -> DONE, or IDLE -> DONE on misalignment.
module dmem_lsu #(
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_vld,
    input  logic              req_mtype,
    input  logic [1:0]        req_len,
    input  logic              req_uns,
    input  logic [N_BITS-1:0] req_addr,
    input  logic [N_BITS-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              req_rdy,
    output logic              mem_req_vld,
    input  logic              mem_req_rdy,
    output logic              mem_we,
    output logic [N_BITS-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [N_BITS-1:0] mem_wdata,
    input  logic              mem_resp_vld,
    input  logic [N_BITS-1:0] mem_resp_data,
    output logic              wb_vld,
    output logic [N_BITS-1:0] wb_data,
    output logic [5:0]        wb_rf,
    output logic              exc_vld,
    output logic [N_BITS-1:0] exc_addr
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    logic [1:0]        state;
    logic              exc_q;
    logic              mtype_q;
    logic [1:0]        len_q;
    logic              uns_q;
    logic [N_BITS-1:0] addr_q;
    logic [N_BITS-1:0] wdata_q;
    logic [4:0]        rd_q;
    logic [N_BITS-1:0] rdata_q;
    logic              accept;
    logic              done;

    function automatic logic misaligned(input logic [1:0] len, input logic [1:0] off);
        logic bad;
        case (len)
            LEN_B:   bad = 1'b0;
            LEN_H:   bad = off[0];
            LEN_W:   bad = (off != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] len, input logic [1:0] off);
        logic [3:0] be;
        case (len)
            LEN_B:   be = 4'b0001 << off;
            LEN_H:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicating the store data lets the memory pick whichever lane mem_be enables.
    function automatic logic [N_BITS-1:0] lane_wdata(input logic [1:0] len, input logic [N_BITS-1:0] wd);
        logic [N_BITS-1:0] r;
        case (len)
            LEN_B:   r = {4{wd[7:0]}};
            LEN_H:   r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [N_BITS-1:0] load_extend(input logic [1:0] len, input logic uns,
                                                      input logic [1:0] off,
                                                      input logic [N_BITS-1:0] rdata);
        logic [N_BITS-1:0]        sh;
        logic signed [7:0]        b;
        logic signed [15:0]       h;
        logic signed [N_BITS-1:0] ext;
        sh = rdata >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (len)
            LEN_B: begin
                if (uns) ext = {{(N_BITS-8){1'b0}}, sh[7:0]};
                else     ext = N_BITS'(b);
            end
            LEN_H: begin
                if (uns) ext = {{(N_BITS-16){1'b0}}, sh[15:0]};
                else     ext = N_BITS'(h);
            end
            default: ext = sh;
        endcase
        return ext;
    endfunction

    assign accept = req_vld && req_rdy;
    assign done   = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            exc_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        exc_q <= misaligned(req_len, req_addr[1:0]);
                        state <= misaligned(req_len, req_addr[1:0]) ? ST_DONE : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_rdy) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_resp_vld) state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand and result registers carry no reset; every output is qualified by state.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && accept) begin
            mtype_q <= req_mtype;
            len_q   <= req_len;
            uns_q   <= req_uns;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
        end
        if (state == ST_WAIT && mem_resp_vld) begin
            rdata_q <= load_extend(len_q, uns_q, addr_q[1:0], mem_resp_data);
        end
    end

    always_comb begin
        req_rdy     = rst_n && (state == ST_IDLE);
        mem_req_vld = (state == ST_REQ);
        mem_we      = mem_req_vld && mtype_q;
        mem_addr    = mem_req_vld ? {addr_q[N_BITS-1:2], 2'b00} : '0;
        mem_be      = mem_req_vld ? lane_be(len_q, addr_q[1:0]) : 4'b0000;
        mem_wdata   = mem_we ? lane_wdata(len_q, wdata_q) : '0;
        wb_vld      = done && !exc_q;
        exc_vld     = done && exc_q;
        exc_addr    = exc_vld ? addr_q : '0;
        wb_data     = (wb_vld && !mtype_q) ? rdata_q : '0;
        wb_rf       = wb_vld ? {rd_q, !mtype_q && (rd_q != 5'd0)} : 6'd0;
    end

endmodule
